// File: rtl/ahb_sram_subordinate.sv
// Zero-wait-state AHB-Lite subordinate wrapping a word-organised SRAM with byte/halfword/word writes.
// Define AHB_MEM_ERR_CHECK_EN to enable address/size error detection and the two-cycle ERROR response.
module ahb_sram_subordinate #(
  parameter int MEM_DEPTH = 32768
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [31:0] mem [0:MEM_DEPTH-1];

  logic             accept;
  logic [29:0]      word_addr;
  logic [IDX_W-1:0] idx_next;
  logic             err_next;
  logic             unused_trans;

  logic             valid_reg;
  logic             write_reg;
  logic             err_reg;
  logic [2:0]       size_reg;
  logic [1:0]       addr_lo_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [3:0]       lane_en;
  logic             do_write;

  assign accept       = HREADY & HTRANS[1];
  assign word_addr    = HADDR[31:2];
  assign unused_trans = HTRANS[0];

`ifdef AHB_MEM_ERR_CHECK_EN
  always_comb begin
    err_next = 1'b0;
    if (HSIZE > 3'd2)                          err_next = 1'b1;
    if (HSIZE == 3'd1 && HADDR[0])             err_next = 1'b1;
    if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00)  err_next = 1'b1;
    if (word_addr >= 30'(MEM_DEPTH))           err_next = 1'b1;
  end
  // Only meaningful when in range; out-of-range transfers are flagged and never touch mem.
  assign idx_next = word_addr[IDX_W-1:0];
`else
  assign err_next = 1'b0;
  assign idx_next = IDX_W'(word_addr % 30'(MEM_DEPTH));
`endif

  // Address-phase capture; held while the bus is stalled so the data phase stays aligned.
  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      valid_reg   <= 1'b0;
      write_reg   <= 1'b0;
      err_reg     <= 1'b0;
      size_reg    <= 3'd0;
      addr_lo_reg <= 2'b00;
      idx_reg     <= '0;
    end else if (HREADY) begin
      valid_reg   <= accept;
      write_reg   <= HWRITE;
      err_reg     <= accept & err_next;
      size_reg    <= HSIZE;
      addr_lo_reg <= HADDR[1:0];
      idx_reg     <= idx_next;
    end
  end

  always_comb begin
    lane_en = 4'b0000;
    case (size_reg)
      3'd0:    lane_en = 4'b0001 << addr_lo_reg;
      3'd1:    lane_en = addr_lo_reg[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  assign do_write = valid_reg & write_reg & ~err_reg & HREADY;

  // No reset on the array: contents survive reset, and valid_reg gates any pending write.
  always_ff @(posedge HCLK) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[idx_reg][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  assign HRDATA = (valid_reg && !write_reg && !err_reg) ? mem[idx_reg] : 32'h0;

`ifdef AHB_MEM_ERR_CHECK_EN
  typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} resp_state_t;

  resp_state_t state_reg;
  logic        hreadyout_reg;
  logic        hresp_reg;

  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      state_reg     <= ST_OKAY;
      hreadyout_reg <= 1'b1;
      hresp_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_OKAY: begin
          if (accept && err_next) begin
            state_reg     <= ST_ERR1;
            hreadyout_reg <= 1'b0;
            hresp_reg     <= 1'b1;
          end
        end
        ST_ERR1: begin
          state_reg     <= ST_ERR2;
          hreadyout_reg <= 1'b1;
          hresp_reg     <= 1'b1;
        end
        ST_ERR2: begin
          if (accept && err_next) begin
            state_reg     <= ST_ERR1;
            hreadyout_reg <= 1'b0;
            hresp_reg     <= 1'b1;
          end else begin
            state_reg     <= ST_OKAY;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= 1'b0;
          end
        end
        default: begin
          state_reg     <= ST_OKAY;
          hreadyout_reg <= 1'b1;
          hresp_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign HREADYOUT = hreadyout_reg;
  assign HRESP     = hresp_reg;
`else
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Self-checking bench for ahb_sram_subordinate: directed scenarios plus randomized traffic
// checked against a word-array reference model built from the lane/error rules.
module tb_ahb_sram_subordinate;
  localparam int DEPTH = 32768;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] haddr = '0;
  logic [2:0]  hsize = '0;
  logic        hwrite = 1'b0;
  logic [31:0] hwdata = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] model [int unsigned];

  always #5 clk = ~clk;

  // Single-subordinate bus: the interconnect returns our own ready as HREADY.
  assign hready = hreadyout;

  ahb_sram_subordinate #(.MEM_DEPTH(DEPTH)) dut (
    .HCLK(clk), .HRESETn(rst), .HADDR(haddr), .HSIZE(hsize), .HWRITE(hwrite),
    .HWDATA(hwdata), .HREADY(hready), .HTRANS(htrans), .HRDATA(hrdata),
    .HREADYOUT(hreadyout), .HRESP(hresp)
  );

  function automatic bit exp_err(input logic [31:0] a, input logic [2:0] s);
    bit e;
    e = (s > 3'd2) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00) || (a[31:2] >= DEPTH);
`ifndef AHB_MEM_ERR_CHECK_EN
    e = 1'b0;
`endif
    return e;
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    return a[31:2] % DEPTH;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] a,
                                        input logic [2:0] s, input logic [31:0] d);
    logic [31:0] mask;
    if (s == 3'd0)      mask = 32'hFF << (8 * a[1:0]);
    else if (s == 3'd1) mask = 32'hFFFF << (16 * a[1]);
    else                mask = 32'hFFFF_FFFF;
    return (old & ~mask) | (d & mask);
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a, input logic [2:0] s);
    if (exp_err(a, s)) return 32'h0;
    return model.exists(widx(a)) ? model[widx(a)] : 32'h0;
  endfunction

  // One complete non-pipelined transfer; entered and left #1 after a rising edge.
  task automatic do_xfer(input bit wr, input logic [31:0] a, input logic [2:0] s,
                         input logic [31:0] d, output logic [31:0] rd,
                         output logic resp, output int stalls);
    htrans = 2'b10; haddr = a; hsize = s; hwrite = wr;
    @(posedge clk); #1;
    htrans = 2'b00; haddr = '0; hsize = '0; hwrite = 1'b0; hwdata = d;
    stalls = 0;
    resp = hresp;
    while (hreadyout !== 1'b1 && stalls < 8) begin
      @(posedge clk); #1;
      stalls++;
      resp = resp | hresp;
    end
    if (stalls >= 8) begin
      mismatched++;
      $display("FAIL xfer_timeout: got hreadyout=%b after %0d cycles required 1", hreadyout, stalls);
    end
    rd = hrdata;
    @(posedge clk); #1;
    $display("xfer wr=%0d addr=%h size=%0d wdata=%h rdata=%h resp=%0b stalls=%0d",
             wr, a, s, d, rd, resp, stalls);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d,
                           output logic resp, output int stalls);
    logic [31:0] rd;
    logic [31:0] old;
    do_xfer(1'b1, a, s, d, rd, resp, stalls);
    if (!exp_err(a, s)) begin
      old = model.exists(widx(a)) ? model[widx(a)] : 32'h0;
      model[widx(a)] = merge(old, a, s, d);
    end
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [2:0] s,
                          output logic [31:0] rd, output logic resp, output int stalls);
    do_xfer(1'b0, a, s, 32'h0, rd, resp, stalls);
  endtask

  task automatic test_reset();
    #2;
    compared++; if (hreadyout !== 1'b1) begin mismatched++; $display("FAIL reset_hreadyout: got %b expected 1", hreadyout); end
    compared++; if (hresp !== 1'b0) begin mismatched++; $display("FAIL reset_hresp: got %b expected 0", hresp); end
    compared++; if (hrdata !== 32'h0) begin mismatched++; $display("FAIL reset_hrdata: got %h expected 0", hrdata); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic resp; int st;
    bus_write(32'h10, 3'd2, 32'hDEADBEEF, resp, st);
    compared++; if (resp !== 1'b0 || st != 0) begin mismatched++; $display("FAIL word_write_resp: got resp=%b stalls=%0d expected 0/0", resp, st); end
    bus_read(32'h10, 3'd2, rd, resp, st);
    compared++; if (rd !== 32'hDEADBEEF) begin mismatched++; $display("FAIL word_read: got %h expected deadbeef", rd); end
    compared++; if (resp !== 1'b0 || st != 0) begin mismatched++; $display("FAIL word_read_resp: got resp=%b stalls=%0d expected 0/0", resp, st); end
  endtask

  task automatic test_lanes();
    logic [31:0] rd; logic resp; int st;
    bus_write(32'h10, 3'd2, 32'h0000_0000, resp, st);
    bus_write(32'h13, 3'd0, 32'hAB5A_5A5A, resp, st);
    bus_write(32'h10, 3'd1, 32'h9999_1234, resp, st);
    bus_read(32'h10, 3'd2, rd, resp, st);
    compared++; if (rd !== 32'hAB00_1234) begin mismatched++; $display("FAIL lanes_read: got %h expected ab001234", rd); end
  endtask

  task automatic test_back_to_back();
    htrans = 2'b10; haddr = 32'h20; hsize = 3'd2; hwrite = 1'b1;
    @(posedge clk); #1;
    haddr = 32'h20; hsize = 3'd2; hwrite = 1'b0; hwdata = 32'h0000_0055;
    compared++; if (hreadyout !== 1'b1) begin mismatched++; $display("FAIL b2b_no_stall: got hreadyout=%b expected 1", hreadyout); end
    @(posedge clk); #1;
    htrans = 2'b00;
    compared++; if (hrdata !== 32'h0000_0055) begin mismatched++; $display("FAIL b2b_read: got %h expected 00000055", hrdata); end
    compared++; if (hresp !== 1'b0) begin mismatched++; $display("FAIL b2b_hresp: got %b expected 0", hresp); end
    @(posedge clk); #1;
    model[8] = 32'h0000_0055;
    $display("xfer b2b write/read addr=00000020 rdata=00000055");
  endtask

  task automatic test_random();
    logic [31:0] rd; logic resp; int st;
    logic [31:0] a; logic [2:0] s; logic [31:0] d; bit e;
    for (int i = 0; i < 64; i++) bus_write(32'(i) << 2, 3'd2, $urandom, resp, st);
    for (int n = 0; n < 250; n++) begin
      a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      s = 3'($urandom_range(0, 3));
      d = $urandom;
      e = exp_err(a, s);
      if ($urandom_range(0, 1) == 1) begin
        bus_write(a, s, d, resp, st);
      end else begin
        bus_read(a, s, rd, resp, st);
        compared++; if (rd !== exp_read(a, s)) begin mismatched++; $display("FAIL rand_read a=%h s=%0d: got %h expected %h", a, s, rd, exp_read(a, s)); end
      end
      compared++; if (resp !== e || st != (e ? 1 : 0)) begin mismatched++; $display("FAIL rand_resp a=%h s=%0d: got resp=%b stalls=%0d expected %b/%0d", a, s, resp, st, e, e ? 1 : 0); end
    end
  endtask

  task automatic test_boundary();
    logic [31:0] rd; logic resp; int st; bit e;
    logic [31:0] a_last; logic [31:0] a_oob;
    a_last = 32'(DEPTH - 1) << 2;
    a_oob  = 32'(DEPTH) << 2;
    bus_write(a_last, 3'd2, 32'hC0FF_EE01, resp, st);
    bus_read(a_last, 3'd2, rd, resp, st);
    compared++; if (rd !== 32'hC0FF_EE01 || resp !== 1'b0) begin mismatched++; $display("FAIL last_index: got %h resp=%b expected c0ffee01/0", rd, resp); end
    e = exp_err(a_oob, 3'd2);
    bus_write(a_oob, 3'd2, 32'h1357_9BDF, resp, st);
    compared++; if (resp !== e || st != (e ? 1 : 0)) begin mismatched++; $display("FAIL oob_write_resp: got resp=%b stalls=%0d expected %b/%0d", resp, st, e, e ? 1 : 0); end
    bus_read(32'h0, 3'd2, rd, resp, st);
    compared++; if (rd !== model[0]) begin mismatched++; $display("FAIL oob_index0: got %h expected %h", rd, model[0]); end
    bus_read(a_oob, 3'd2, rd, resp, st);
    compared++; if (rd !== exp_read(a_oob, 3'd2) || resp !== e) begin mismatched++; $display("FAIL oob_read: got %h resp=%b expected %h/%b", rd, resp, exp_read(a_oob, 3'd2), e); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic resp; int st; bit e;
    e = exp_err(32'h12, 3'd2);
    bus_read(32'h12, 3'd2, rd, resp, st);
    compared++; if (rd !== exp_read(32'h12, 3'd2)) begin mismatched++; $display("FAIL misaligned_read: got %h expected %h", rd, exp_read(32'h12, 3'd2)); end
    compared++; if (resp !== e || st != (e ? 1 : 0)) begin mismatched++; $display("FAIL misaligned_resp: got resp=%b stalls=%0d expected %b/%0d", resp, st, e, e ? 1 : 0); end
    bus_write(32'h11, 3'd1, 32'h7766_5544, resp, st);
    bus_read(32'h10, 3'd2, rd, resp, st);
    compared++; if (rd !== model[4]) begin mismatched++; $display("FAIL misaligned_half: got %h expected %h", rd, model[4]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic resp; int st;
    htrans = 2'b10; haddr = 32'h14; hsize = 3'd2; hwrite = 1'b1;
    @(posedge clk); #1;
    htrans = 2'b00; hwrite = 1'b0; hwdata = ~model[5];
    rst = 1'b1;
    #1;
    compared++; if (hreadyout !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'h0) begin mismatched++; $display("FAIL reset_mid_outputs: got ready=%b resp=%b rdata=%h expected 1/0/0", hreadyout, hresp, hrdata); end
    @(posedge clk); #1 rst = 1'b0;
    bus_read(32'h14, 3'd2, rd, resp, st);
    compared++; if (rd !== model[5]) begin mismatched++; $display("FAIL reset_mid_unmodified: got %h expected %h", rd, model[5]); end
`ifdef AHB_MEM_ERR_CHECK_EN
    htrans = 2'b10; haddr = 32'h0; hsize = 3'd3; hwrite = 1'b0;
    @(posedge clk); #1;
    htrans = 2'b00;
    compared++; if (hreadyout !== 1'b0 || hresp !== 1'b1) begin mismatched++; $display("FAIL err1_state: got ready=%b resp=%b expected 0/1", hreadyout, hresp); end
    rst = 1'b1;
    #1;
    compared++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin mismatched++; $display("FAIL reset_in_err1: got ready=%b resp=%b expected 1/0", hreadyout, hresp); end
    @(posedge clk); #1 rst = 1'b0;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_word();
    test_lanes();
    test_back_to_back();
    test_random();
    test_boundary();
    test_misaligned();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ahb_sram_subordinate.md
# ahb_sram_subordinate

Single-port word-organised SRAM exposed as a zero-wait-state AHB-Lite subordinate. It serves as the processor's data memory on the data AHB bus, sitting beside the instruction memory. Byte, halfword and word writes are supported; reads always return the full 32-bit word. Contents can be preloaded in simulation through the word array `mem`.

## Interface
Parameters:
- `MEM_DEPTH`, default 32768: number of 32-bit words in `mem`.

Ports:
- `HCLK` in 1: the single clock; all state updates on the rising edge.
- `HRESETn` in 1: asynchronous, active-high reset (asserted when 1; name kept per codebase convention).
- `HADDR` in 32: byte address, sampled in the address phase.
- `HSIZE` in 3: 0 = byte, 1 = halfword, 2 = word.
- `HWRITE` in 1: 1 = write, 0 = read.
- `HWDATA` in 32: write data, used in the data phase.
- `HREADY` in 1: bus ready; the address phase is sampled only when this is 1.
- `HTRANS` in 2: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- `HRDATA` out 32: read data.
- `HREADYOUT` out 1: subordinate ready.
- `HRESP` out 1: 0 OKAY, 1 ERROR.

Storage is a `logic [31:0] mem [0:MEM_DEPTH-1]` array, indexed by `HADDR[31:2]`. It is not cleared by reset.

## Operation
- A transfer is accepted when `HREADY`=1 and `HTRANS[1]`=1 (NONSEQ or SEQ) on a rising edge.
  - On acceptance, register: valid, write, size, word index, and `HADDR[1:0]`.
  - IDLE and BUSY transfers are not accepted and always receive an OKAY, zero-wait response.
- Error check (with the macro below): an accepted transfer is in error if any of these holds:
  - `HSIZE` > 2;
  - halfword with `HADDR[0]`=1;
  - word with `HADDR[1:0]` != 0;
  - word index >= `MEM_DEPTH`.
- Write data phase (no error): on the edge ending the data phase, update only the addressed lanes (little-endian).
  - Byte: lane k = `HADDR[1:0]` is written from `HWDATA[8k+7:8k]`.
  - Halfword: lanes {2h+1, 2h}, where h = `HADDR[1]`.
  - Word: all four lanes.
- Read data phase (no error): `HRDATA` = `mem[registered index]`, combinational, so a read immediately after a write to the same word returns the new data.
- When no read data phase is active, `HRDATA` = 0.
- Response state machine:
  - State OKAY: `HREADYOUT`=1, `HRESP`=0.
  - State ERR1: `HREADYOUT`=0, `HRESP`=1.
  - State ERR2: `HREADYOUT`=1, `HRESP`=1.
  - Transitions: an accepted erroneous transfer goes OKAY→ERR1. ERR1→ERR2 unconditionally. ERR2→OKAY, unless a new erroneous transfer is accepted in ERR2, in which case ERR2→ERR1.
  - An erroneous write never modifies `mem`. An erroneous read drives `HRDATA`=0.
- A new transfer may be accepted in the same cycle a data phase completes (pipelined back-to-back transfers).

## Timing
- Write latency: data is written on the rising edge one cycle after the address phase.
- Read latency: data is valid during the cycle after the address phase; there are zero wait states.
- An error response takes exactly 2 data-phase cycles. No address is accepted during ERR1, because `HREADY` is low.
- Reset values: `HREADYOUT`=1, `HRESP`=0, `HRDATA`=0, pending phase cleared.
- Reset asserted mid-transfer: the pending write is discarded and the state returns to OKAY immediately, asynchronously.
- Boundaries:
  - Word index `MEM_DEPTH`-1 is valid.
  - Index `MEM_DEPTH` is an error with the macro defined; without the macro it wraps to index 0.

## Configuration
- `AHB_MEM_ERR_CHECK_EN` defined: error checking and the ERR1/ERR2 response are implemented as above.
- Undefined:
  - Every transfer completes OKAY with zero wait states; `HRESP` is tied to 0 and `HREADYOUT` to 1.
  - The word index is taken modulo `MEM_DEPTH`.
  - Misaligned low address bits are ignored for lane selection: halfword uses `HADDR[1]` only, word uses all lanes.
  - `HSIZE` > 2 is treated as word.

## Test plan
- Word write then read: write 0xDEADBEEF at 0x10, then read 0x10 → `HRDATA`=0xDEADBEEF in the read data phase; `HRESP`=0 and `HREADYOUT`=1 throughout.
- Byte/halfword lanes: preload word 0x10=0x00000000; write byte 0xAB at 0x13 and halfword 0x1234 at 0x10 → read 0x10 returns 0xAB001234.
- Back-to-back: write 0x55 at 0x20, then read 0x20 in the next address phase → `HRDATA`=0x00000055 with no stall.
- Out of range (macro on, `MEM_DEPTH`=32768): write at 0x20000 → `HREADYOUT` 0 then 1 with `HRESP`=1 for 2 cycles; a subsequent read of index 0 is unchanged.
- Misaligned word read at 0x12 (macro on) → 2-cycle ERROR with `HRDATA`=0. With the macro off → OKAY, returns `mem[4]`.
- Reset: assert `HRESETn`=1 in a write data phase → `HREADYOUT`=1, `HRESP`=0, `HRDATA`=0 immediately; the target word is unmodified.
